// File: rtl/bootstrap_sequencer_if.sv
// -----------------------------------------------------------------------------
// bootstrap_sequencer_if
// Bundles the boot-source handshake and the microcode-RAM bootstrap bus that
// the bootstrap_sequencer drives.
//   master : the sequencer. Drives SRC_REQ/SRC_ADDR, the BOOTSTRAP_* RAM bus
//            and the status lines; receives SRC_ACK/SRC_DATA.
//   slave  : the environment (boot source plus control logic).
// Signals:
//   SRC_REQ        request the byte at SRC_ADDR from the boot source
//   SRC_ADDR[12:0] source byte address (0..NUM_BYTES)
//   SRC_ACK        source presents valid SRC_DATA this cycle
//   SRC_DATA[7:0]  source byte
//   BOOTSTRAP_ADDR[11:0], BOOTSTRAP_DATA[7:0], BOOTSTRAP_N_WE  RAM write port
//   N_BOOTED       high while bootstrapping, low once the image is verified
//   CPU_N_RST      active-low core reset
//   BOOT_ERROR     sticky checksum-mismatch flag
//   BOOT_BUSY      high while the sequence is still in progress
// -----------------------------------------------------------------------------
interface bootstrap_sequencer_if;
   logic        SRC_REQ;
   logic [12:0] SRC_ADDR;
   logic        SRC_ACK;
   logic [7:0]  SRC_DATA;
   logic [11:0] BOOTSTRAP_ADDR;
   logic [7:0]  BOOTSTRAP_DATA;
   logic        BOOTSTRAP_N_WE;
   logic        N_BOOTED;
   logic        CPU_N_RST;
   logic        BOOT_ERROR;
   logic        BOOT_BUSY;

   modport master (
      output SRC_REQ, SRC_ADDR,
      input  SRC_ACK, SRC_DATA,
      output BOOTSTRAP_ADDR, BOOTSTRAP_DATA, BOOTSTRAP_N_WE,
      output N_BOOTED, CPU_N_RST, BOOT_ERROR, BOOT_BUSY
   );

   modport slave (
      input  SRC_REQ, SRC_ADDR,
      output SRC_ACK, SRC_DATA,
      input  BOOTSTRAP_ADDR, BOOTSTRAP_DATA, BOOTSTRAP_N_WE,
      input  N_BOOTED, CPU_N_RST, BOOT_ERROR, BOOT_BUSY
   );
endinterface

// File: rtl/bootstrap_sequencer.sv
// -----------------------------------------------------------------------------
// bootstrap_sequencer
// After reset, fetches NUM_BYTES image bytes plus one trailing checksum byte
// from a byte-wide boot source, writes the image into the microcode RAM
// through the BOOTSTRAP_* port, verifies that image + checksum sums to zero
// (mod 256) and only then releases the CPU core from reset.
// Ports:
//   CLK    system clock, rising edge
//   N_RST  asynchronous active-low reset
//   bus    bootstrap_sequencer_if.master (source handshake, RAM port, status)
// Parameters:
//   NUM_BYTES  image length (1..4096); checksum at source address NUM_BYTES
//   WE_CYCLES  cycles BOOTSTRAP_N_WE is held low per byte (1..7)
//   RST_HOLD   cycles between N_BOOTED falling and CPU_N_RST rising (0..7)
// -----------------------------------------------------------------------------
module bootstrap_sequencer #(
   parameter int NUM_BYTES = 4096,
   parameter int WE_CYCLES = 2,
   parameter int RST_HOLD  = 2
) (
   input  logic                    CLK,
   input  logic                    N_RST,
   bootstrap_sequencer_if.master   bus
);

   localparam logic [12:0] IMG_LEN  = 13'(NUM_BYTES);
   localparam logic [2:0]  WE_LAST  = 3'(WE_CYCLES - 1);
   localparam logic [2:0]  RST_LAST = 3'((RST_HOLD > 0) ? (RST_HOLD - 1) : 0);

   typedef enum logic [2:0] {
      S_FETCH,
      S_SETUP,
      S_WRITE,
      S_HOLD,
      S_CHECK,
      S_RELEASE,
      S_DONE,
      S_ERROR
   } state_t;

   state_t      state_q;
   logic [12:0] idx_q;        // next source byte to fetch
   logic [7:0]  sum_q;        // running mod-256 sum of image bytes
   logic [7:0]  chk_q;        // captured checksum byte
   logic [2:0]  cnt_q;        // shared WRITE / RELEASE cycle counter

   logic        src_req_q;
   logic [12:0] src_addr_q;
   logic [11:0] bs_addr_q;
   logic [7:0]  bs_data_q;
   logic        bs_n_we_q;
   logic        n_booted_q;
   logic        cpu_n_rst_q;
   logic        boot_error_q;
   logic        boot_busy_q;

   logic [7:0]  check_total;
   assign check_total = sum_q + chk_q;

   always_ff @(posedge CLK or negedge N_RST) begin
      if (!N_RST) begin
         state_q      <= S_FETCH;
         idx_q        <= '0;
         sum_q        <= '0;
         chk_q        <= '0;
         cnt_q        <= '0;
         src_req_q    <= 1'b0;
         src_addr_q   <= '0;
         bs_addr_q    <= '0;
         bs_data_q    <= '0;
         bs_n_we_q    <= 1'b1;
         n_booted_q   <= 1'b1;
         cpu_n_rst_q  <= 1'b0;
         boot_error_q <= 1'b0;
         boot_busy_q  <= 1'b1;
      end else begin
         case (state_q)
            S_FETCH: begin
               // First FETCH cycle raises the request; subsequent cycles wait
               // for the acknowledge with REQ/ADDR frozen.
               if (!src_req_q) begin
                  src_req_q  <= 1'b1;
                  src_addr_q <= idx_q;
               end else if (bus.SRC_ACK) begin
                  src_req_q <= 1'b0;
                  if (idx_q < IMG_LEN) begin
                     bs_addr_q <= idx_q[11:0];
                     bs_data_q <= bus.SRC_DATA;
                     sum_q     <= sum_q + bus.SRC_DATA;
                     state_q   <= S_SETUP;
                  end else begin
                     chk_q   <= bus.SRC_DATA;
                     state_q <= S_CHECK;
                  end
               end
            end

            S_SETUP: begin
               // Address/data have been stable for one cycle; open the strobe.
               bs_n_we_q <= 1'b0;
               cnt_q     <= '0;
               state_q   <= S_WRITE;
            end

            S_WRITE: begin
               if (cnt_q == WE_LAST) begin
                  bs_n_we_q <= 1'b1;
                  state_q   <= S_HOLD;
               end else begin
                  cnt_q <= cnt_q + 3'd1;
               end
            end

            S_HOLD: begin
               idx_q   <= idx_q + 13'd1;
               state_q <= S_FETCH;
            end

            S_CHECK: begin
               if (check_total == 8'h00) begin
                  n_booted_q <= 1'b0;
                  cnt_q      <= '0;
                  if (RST_HOLD == 0) begin
                     // No hold time: release the core on the same edge.
                     cpu_n_rst_q <= 1'b1;
                     boot_busy_q <= 1'b0;
                     state_q     <= S_DONE;
                  end else begin
                     state_q <= S_RELEASE;
                  end
               end else begin
                  boot_error_q <= 1'b1;
                  boot_busy_q  <= 1'b0;
                  state_q      <= S_ERROR;
               end
            end

            S_RELEASE: begin
               if (cnt_q == RST_LAST) begin
                  cpu_n_rst_q <= 1'b1;
                  boot_busy_q <= 1'b0;
                  state_q     <= S_DONE;
               end else begin
                  cnt_q <= cnt_q + 3'd1;
               end
            end

            S_DONE: begin
               // Terminal: all outputs already hold their final values and
               // SRC_ACK is ignored.
               state_q <= S_DONE;
            end

            S_ERROR: begin
               // Terminal until N_RST; the core stays in reset.
               state_q <= S_ERROR;
            end
         endcase
      end
   end

   assign bus.SRC_REQ        = src_req_q;
   assign bus.SRC_ADDR       = src_addr_q;
   assign bus.BOOTSTRAP_ADDR = bs_addr_q;
   assign bus.BOOTSTRAP_DATA = bs_data_q;
   assign bus.BOOTSTRAP_N_WE = bs_n_we_q;
   assign bus.N_BOOTED       = n_booted_q;
   assign bus.CPU_N_RST      = cpu_n_rst_q;
   assign bus.BOOT_ERROR     = boot_error_q;
   assign bus.BOOT_BUSY      = boot_busy_q;

   // Safety properties of the boot sequence.
   a_no_write_after_boot: assert property (@(posedge CLK) disable iff (!N_RST)
      !(!bs_n_we_q && !n_booted_q));
   a_cpu_held_while_booting: assert property (@(posedge CLK) disable iff (!N_RST)
      !(cpu_n_rst_q && n_booted_q));
   a_src_addr_range: assert property (@(posedge CLK) disable iff (!N_RST)
      src_addr_q <= IMG_LEN);
   a_ram_addr_range: assert property (@(posedge CLK) disable iff (!N_RST)
      {1'b0, bs_addr_q} <= (IMG_LEN - 13'd1));
   a_stable_during_write: assert property (@(posedge CLK) disable iff (!N_RST)
      (!bs_n_we_q && !$past(bs_n_we_q)) |-> ($stable(bs_addr_q) && $stable(bs_data_q)));

endmodule

// File: tb/tb_bootstrap_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bootstrap_sequencer
// Two instances: a 4-byte image (WE_CYCLES=2, RST_HOLD=2) for the functional
// scenarios and a full 4096-byte image for the address boundary case.
// Expected RAM writes are queued when an image is loaded into the source
// model and compared against writes observed on the RAM port.
// -----------------------------------------------------------------------------
module tb_bootstrap_sequencer;

   typedef struct {
      logic [11:0] addr;
      logic [7:0]  data;
      int          len;
      bit          stable;
   } wr_t;

   localparam logic [38:0] VEC_RESET = {1'b0, 13'd0, 12'd0,   8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
   localparam logic [38:0] VEC_DONE  = {1'b0, 13'd4, 12'd3,   8'h04, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
   localparam logic [38:0] VEC_ERROR = {1'b0, 13'd4, 12'd3,   8'h04, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

   logic clk = 1'b0;
   logic n_rst_a = 1'b0;
   logic n_rst_b = 1'b0;
   always #5 clk = ~clk;

   bootstrap_sequencer_if ifa ();
   bootstrap_sequencer_if ifb ();

   bootstrap_sequencer #(.NUM_BYTES(4), .WE_CYCLES(2), .RST_HOLD(2)) dut_a (
      .CLK   (clk),
      .N_RST (n_rst_a),
      .bus   (ifa)
   );

   bootstrap_sequencer #(.NUM_BYTES(4096), .WE_CYCLES(2), .RST_HOLD(2)) dut_b (
      .CLK   (clk),
      .N_RST (n_rst_b),
      .bus   (ifb)
   );

   int total = 0;
   int bad   = 0;

   logic [7:0] img_a [0:4];
   int  ack_delay_a = 0;
   bit  spur_a = 0;
   wr_t exp_q[$];
   wr_t obs_q[$];

   int  req_runs[$];
   int  req_glitch;
   int  first_req_addr;

   int          wr_cnt_b = 0;
   logic [11:0] last_addr_b = '0;
   logic [12:0] max_src_b = '0;

   // Boot source model for instance A: ACK after ack_delay_a waiting cycles.
   initial begin
      int waitc;
      waitc = 0;
      ifa.SRC_ACK  = 1'b0;
      ifa.SRC_DATA = 8'h00;
      forever begin
         @(negedge clk);
         if (spur_a) begin
            ifa.SRC_ACK  = 1'($urandom_range(0, 1));
            ifa.SRC_DATA = 8'($urandom);
         end else if (ifa.SRC_REQ && !ifa.SRC_ACK) begin
            if (waitc == ack_delay_a) begin
               ifa.SRC_ACK  = 1'b1;
               ifa.SRC_DATA = (ifa.SRC_ADDR <= 13'd4) ? img_a[ifa.SRC_ADDR[2:0]] : 8'h00;
               waitc = 0;
            end else begin
               waitc++;
            end
         end else begin
            ifa.SRC_ACK = 1'b0;
            waitc = 0;
         end
      end
   end

   // Observed-write collector for instance A.
   initial begin
      int  len;
      wr_t cur;
      len = 0;
      cur = '{addr: '0, data: '0, len: 0, stable: 1'b1};
      forever begin
         @(negedge clk);
         if (!n_rst_a) begin
            len = 0;
         end else if (!ifa.BOOTSTRAP_N_WE) begin
            if (len == 0) begin
               cur.addr   = ifa.BOOTSTRAP_ADDR;
               cur.data   = ifa.BOOTSTRAP_DATA;
               cur.stable = 1'b1;
            end else if (ifa.BOOTSTRAP_ADDR !== cur.addr || ifa.BOOTSTRAP_DATA !== cur.data) begin
               cur.stable = 1'b0;
            end
            len++;
         end else if (len > 0) begin
            cur.len = len;
            obs_q.push_back(cur);
            len = 0;
         end
      end
   end

   // Instance B: all-zero source with immediate ACK, plus write/address tracking.
   initial begin
      bit prev_low;
      prev_low = 1'b0;
      ifb.SRC_ACK  = 1'b0;
      ifb.SRC_DATA = 8'h00;
      forever begin
         @(negedge clk);
         ifb.SRC_ACK = (ifb.SRC_REQ && !ifb.SRC_ACK);
         if (n_rst_b) begin
            if (!ifb.BOOTSTRAP_N_WE && !prev_low) begin
               wr_cnt_b++;
               last_addr_b = ifb.BOOTSTRAP_ADDR;
            end
            prev_low = !ifb.BOOTSTRAP_N_WE;
            if (ifb.SRC_REQ && ifb.SRC_ADDR > max_src_b) max_src_b = ifb.SRC_ADDR;
         end
      end
   end

   function automatic logic [38:0] vec_a();
      return {ifa.SRC_REQ, ifa.SRC_ADDR, ifa.BOOTSTRAP_ADDR, ifa.BOOTSTRAP_DATA,
              ifa.BOOTSTRAP_N_WE, ifa.N_BOOTED, ifa.CPU_N_RST, ifa.BOOT_ERROR, ifa.BOOT_BUSY};
   endfunction

   function automatic logic [38:0] vec_b();
      return {ifb.SRC_REQ, ifb.SRC_ADDR, ifb.BOOTSTRAP_ADDR, ifb.BOOTSTRAP_DATA,
              ifb.BOOTSTRAP_N_WE, ifb.N_BOOTED, ifb.CPU_N_RST, ifb.BOOT_ERROR, ifb.BOOT_BUSY};
   endfunction

   // Reset instance A, load an image into the source model, queue the
   // expected RAM writes and release reset on a falling clock edge.
   task automatic start_a(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input logic [7:0] b3, input logic [7:0] ck, input int delay);
      n_rst_a = 1'b0;
      spur_a  = 1'b0;
      repeat (2) @(negedge clk);
      exp_q.delete();
      obs_q.delete();
      img_a[0] = b0; img_a[1] = b1; img_a[2] = b2; img_a[3] = b3; img_a[4] = ck;
      ack_delay_a = delay;
      for (int i = 0; i < 4; i++)
         exp_q.push_back('{addr: 12'(i), data: img_a[i], len: 2, stable: 1'b1});
      n_rst_a = 1'b1;
   endtask

   // Step instance A until BOOT_BUSY falls or the budget expires, recording
   // the handshake shape and the N_BOOTED / CPU_N_RST edge cycles.
   task automatic run_a(input int budget, output int cycles, output int nb_fall, output int cpu_rise);
      bit          prev_req;
      logic [12:0] prev_addr;
      int          run;
      prev_req = 1'b0; prev_addr = '0; run = 0;
      cycles = 0; nb_fall = -1; cpu_rise = -1;
      req_runs.delete(); req_glitch = 0; first_req_addr = -1;
      while (cycles < budget) begin
         @(negedge clk);
         cycles++;
         if (ifa.SRC_REQ) begin
            if (first_req_addr < 0) first_req_addr = int'(ifa.SRC_ADDR);
            if (prev_req && ifa.SRC_ADDR !== prev_addr) req_glitch++;
            if (!ifa.BOOTSTRAP_N_WE) req_glitch++;
            run++;
         end else if (prev_req) begin
            req_runs.push_back(run);
            run = 0;
         end
         prev_req  = ifa.SRC_REQ;
         prev_addr = ifa.SRC_ADDR;
         if (nb_fall < 0 && !ifa.N_BOOTED) nb_fall = cycles;
         if (cpu_rise < 0 && ifa.CPU_N_RST) cpu_rise = cycles;
         if (!ifa.BOOT_BUSY) break;
      end
   endtask

   task automatic test_reset();
      n_rst_a = 1'b0;
      n_rst_b = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if (vec_a() !== VEC_RESET) begin
         bad++; $display("FAIL reset_outputs_a: got %h want %h", vec_a(), VEC_RESET);
      end
      total++;
      if (vec_b() !== VEC_RESET) begin
         bad++; $display("FAIL reset_outputs_b: got %h want %h", vec_b(), VEC_RESET);
      end
      $display("test_reset: outputs sampled under reset");
   endtask

   task automatic test_good_image();
      int cyc, nbf, cpr;
      wr_t e, o;
      start_a(8'h01, 8'h02, 8'h03, 8'h04, 8'hF6, 0);
      run_a(200, cyc, nbf, cpr);
      total++;
      if (ifa.BOOT_BUSY !== 1'b0) begin
         bad++; $display("FAIL good_timeout: busy=%b after %0d cycles want 0", ifa.BOOT_BUSY, cyc);
      end
      total++;
      if (obs_q.size() != 4) begin
         bad++; $display("FAIL good_write_count: got %0d want 4", obs_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         total++;
         if (o.addr !== e.addr || o.data !== e.data || o.len != e.len || !o.stable) begin
            bad++; $display("FAIL good_write: got a=%h d=%h len=%0d st=%0b want a=%h d=%h len=%0d st=1",
                            o.addr, o.data, o.len, o.stable, e.addr, e.data, e.len);
         end
         $display("good write a=%h d=%h len=%0d", o.addr, o.data, o.len);
      end
      total++;
      if (nbf != 27) begin
         bad++; $display("FAIL good_nbooted_cycle: got %0d want 27", nbf);
      end
      total++;
      if (cpr != 29) begin
         bad++; $display("FAIL good_cpu_rst_cycle: got %0d want 29", cpr);
      end
      total++;
      if (vec_a() !== VEC_DONE) begin
         bad++; $display("FAIL good_final_outputs: got %h want %h", vec_a(), VEC_DONE);
      end
   endtask

   task automatic test_spurious(input logic [38:0] want, input string name);
      int diffs;
      diffs = 0;
      spur_a = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (vec_a() !== want) diffs++;
      end
      spur_a = 1'b0;
      @(negedge clk);
      total++;
      if (diffs != 0 || vec_a() !== want) begin
         bad++; $display("FAIL spurious_%s: %0d changed cycles, now %h want %h", name, diffs, vec_a(), want);
      end
      $display("spurious ack in %s: changed cycles=%0d", name, diffs);
   endtask

   task automatic test_bad_checksum();
      int cyc, nbf, cpr, reqs;
      wr_t e, o;
      start_a(8'h01, 8'h02, 8'h03, 8'h04, 8'hF5, 0);
      run_a(200, cyc, nbf, cpr);
      total++;
      if (obs_q.size() != 4) begin
         bad++; $display("FAIL bad_write_count: got %0d want 4", obs_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         total++;
         if (o.addr !== e.addr || o.data !== e.data || o.len != e.len || !o.stable) begin
            bad++; $display("FAIL bad_write: got a=%h d=%h len=%0d want a=%h d=%h len=%0d",
                            o.addr, o.data, o.len, e.addr, e.data, e.len);
         end
         $display("bad-checksum write a=%h d=%h len=%0d", o.addr, o.data, o.len);
      end
      reqs = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ifa.SRC_REQ) reqs++;
      end
      total++;
      if (reqs != 0) begin
         bad++; $display("FAIL bad_req_after_error: got %0d req cycles want 0", reqs);
      end
      total++;
      if (vec_a() !== VEC_ERROR) begin
         bad++; $display("FAIL bad_final_outputs: got %h want %h", vec_a(), VEC_ERROR);
      end
   endtask

   task automatic test_ack_delay();
      int cyc, nbf, cpr, r;
      wr_t e, o;
      start_a(8'h10, 8'h20, 8'h30, 8'h40, 8'h60, 5);
      run_a(400, cyc, nbf, cpr);
      total++;
      if (req_runs.size() != 5) begin
         bad++; $display("FAIL delay_req_count: got %0d want 5", req_runs.size());
      end
      while (req_runs.size() > 0) begin
         r = req_runs.pop_front();
         total++;
         if (r != 6) begin
            bad++; $display("FAIL delay_req_len: got %0d want 6", r);
         end
      end
      total++;
      if (req_glitch != 0) begin
         bad++; $display("FAIL delay_req_stability: got %0d violations want 0", req_glitch);
      end
      total++;
      if (obs_q.size() != 4) begin
         bad++; $display("FAIL delay_write_count: got %0d want 4", obs_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         total++;
         if (o.addr !== e.addr || o.data !== e.data || o.len != e.len || !o.stable) begin
            bad++; $display("FAIL delay_write: got a=%h d=%h len=%0d want a=%h d=%h len=%0d",
                            o.addr, o.data, o.len, e.addr, e.data, e.len);
         end
         $display("delayed-ack write a=%h d=%h len=%0d", o.addr, o.data, o.len);
      end
      total++;
      if (ifa.N_BOOTED !== 1'b0 || ifa.BOOT_ERROR !== 1'b0 || ifa.CPU_N_RST !== 1'b1) begin
         bad++; $display("FAIL delay_final: got nb=%b err=%b cpu=%b want 0 0 1",
                         ifa.N_BOOTED, ifa.BOOT_ERROR, ifa.CPU_N_RST);
      end
   endtask

   task automatic test_reset_mid_write();
      int cyc, nbf, cpr;
      wr_t e, o;
      start_a(8'h01, 8'h02, 8'h03, 8'h04, 8'hF6, 0);
      repeat (10) @(negedge clk);
      total++;
      if (ifa.BOOTSTRAP_N_WE !== 1'b0 || ifa.BOOTSTRAP_ADDR !== 12'd1) begin
         bad++; $display("FAIL midrst_in_write: got nwe=%b a=%h want 0 001", ifa.BOOTSTRAP_N_WE, ifa.BOOTSTRAP_ADDR);
      end
      n_rst_a = 1'b0;
      #1;
      total++;
      if (ifa.BOOTSTRAP_N_WE !== 1'b1 || ifa.SRC_REQ !== 1'b0 || ifa.SRC_ADDR !== 13'd0) begin
         bad++; $display("FAIL midrst_async: got nwe=%b req=%b sa=%h want 1 0 0000",
                         ifa.BOOTSTRAP_N_WE, ifa.SRC_REQ, ifa.SRC_ADDR);
      end
      $display("reset pulse during write: nwe=%b", ifa.BOOTSTRAP_N_WE);
      start_a(8'h01, 8'h02, 8'h03, 8'h04, 8'hF6, 0);
      run_a(200, cyc, nbf, cpr);
      total++;
      if (first_req_addr != 0) begin
         bad++; $display("FAIL midrst_restart_addr: got %0d want 0", first_req_addr);
      end
      total++;
      if (obs_q.size() != 4) begin
         bad++; $display("FAIL midrst_write_count: got %0d want 4", obs_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         total++;
         if (o.addr !== e.addr || o.data !== e.data || o.len != e.len || !o.stable) begin
            bad++; $display("FAIL midrst_write: got a=%h d=%h len=%0d want a=%h d=%h len=%0d",
                            o.addr, o.data, o.len, e.addr, e.data, e.len);
         end
         $display("restart write a=%h d=%h len=%0d", o.addr, o.data, o.len);
      end
      total++;
      if (nbf != 27 || vec_a() !== VEC_DONE) begin
         bad++; $display("FAIL midrst_complete: got nb_fall=%0d out=%h want 27 %h", nbf, vec_a(), VEC_DONE);
      end
   endtask

   task automatic test_full_image();
      int cyc;
      cyc = 0;
      @(negedge clk);
      n_rst_b = 1'b1;
      while (cyc < 30000 && ifb.BOOT_BUSY) begin
         @(negedge clk);
         cyc++;
      end
      total++;
      if (ifb.BOOT_BUSY !== 1'b0) begin
         bad++; $display("FAIL full_timeout: busy=%b after %0d cycles want 0", ifb.BOOT_BUSY, cyc);
      end
      total++;
      if (wr_cnt_b != 4096) begin
         bad++; $display("FAIL full_write_count: got %0d want 4096", wr_cnt_b);
      end
      total++;
      if (last_addr_b !== 12'hFFF) begin
         bad++; $display("FAIL full_last_addr: got %h want fff", last_addr_b);
      end
      total++;
      if (max_src_b !== 13'h1000) begin
         bad++; $display("FAIL full_checksum_addr: got %h want 1000", max_src_b);
      end
      total++;
      if (ifb.N_BOOTED !== 1'b0 || ifb.BOOT_ERROR !== 1'b0 || ifb.CPU_N_RST !== 1'b1) begin
         bad++; $display("FAIL full_final: got nb=%b err=%b cpu=%b want 0 0 1",
                         ifb.N_BOOTED, ifb.BOOT_ERROR, ifb.CPU_N_RST);
      end
      $display("full image: writes=%0d last=%h cycles=%0d", wr_cnt_b, last_addr_b, cyc);
   endtask

   initial begin
      test_reset();
      test_good_image();
      test_spurious(VEC_DONE, "done");
      test_bad_checksum();
      test_spurious(VEC_ERROR, "error");
      test_ack_delay();
      test_reset_mid_write();
      test_full_image();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
